lc3_controller: RTL and testbench
=================================

Name: lc3_controller

Overview:
- Pipeline sequencer for the LC3 core.
- Generates per-stage enables for fetch, decode, execute and writeback, plus PC-update and branch-taken control for the fetch stage.
- Stalls the pipeline for data-memory accesses (including the two-phase indirect access) and for control-flow instructions.
- Sits beside the fetch, decode, execute, writeback and memaccess blocks and drives their enable inputs.

Parameters:
- MEM_TIMEOUT, 64: maximum cycles spent in any single memory phase without complete_data before mem_err is set (range 1..255).

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- complete_instr  input  1  instruction memory returned valid data this cycle.
- complete_data  input  1  data memory finished current phase this cycle.
- ir  input  16  instruction currently in decode.
- ir_exec  input  16  instruction currently in execute.
- nzp  input  3  condition codes from writeback ({N,Z,P}).
- enable_fetch  output  1  fetch stage enable (drives instrmem_rd).
- enable_updatepc  output  1  allow PC register update.
- enable_decode  output  1  decode stage enable.
- enable_execute  output  1  execute stage enable.
- enable_writeback  output  1  writeback stage enable.
- br_taken  output  1  fetch selects taddr when updating PC.
- mem_state  output  2  0 = read, 1 = write, 2 = indirect address read, 3 = idle.
- mem_err  output  1  sticky memory timeout flag.

Behaviour:
- Reset (reset = 0, async):
  - all enables = 0, br_taken = 0, mem_state = 3, mem_err = 0.
  - valid flags v_dec, v_exe, v_wb = 0; FSM = RUN.
- Opcode classes (bits [15:12]):
  - MEM = LD 0010, LDR 0110, LDI 1010, ST 0011, STR 0111, STI 1011.
  - CTRL = BR 0000, JMP 1100.
  - All others are ALU-class.
- Pipeline fill:
  - First rising edge with reset = 1: enable_fetch = 1, enable_updatepc = 1.
  - Each stage's valid flag loads the previous stage's valid when the pipeline advances.
  - enable_decode/execute/writeback = v_dec/v_exe/v_wb, gated by state.
  - Decode is first enabled the 2nd cycle after reset release, execute the 3rd, writeback the 4th.
- Instruction wait: in RUN with complete_instr = 0:
  - enable_updatepc, enable_decode, enable_execute and enable_writeback are all 0; valid flags hold.
  - enable_fetch stays 1.
- MEM stall: cycle E has enable_execute = 1 and ir_exec is MEM class.
  - E+1: all enables = 0; mem_state = 0 (LD/LDR), 1 (ST/STR) or 2 (LDI/STI).
  - mem_state = 2 holds until complete_data = 1. Next cycle: 0 for LDI, 1 for STI.
  - The final phase holds until complete_data = 1.
  - The cycle after the final phase: mem_state = 3 and enables restore.
  - enable_writeback = 1 for that cycle only if the op was a load; stores write back nothing (v_wb cleared).
- CTRL stall: cycle T has enable_decode = 1 and ir is CTRL class.
  - T+1: enable_execute = 1 for the branch; enable_fetch = enable_updatepc = enable_decode = 0; v_dec cleared.
  - T+2:
    - br_taken = 1 if ir_exec is JMP, or BR with (ir_exec[11:9] & nzp) != 0.
    - enable_updatepc = 1, enable_fetch = 0, enable_writeback = 0.
  - T+3: br_taken = 0, enable_fetch = 1, enable_updatepc = 1; fill restarts (next decode at T+4).
  - BR with ir[11:9] = 000 is never taken.
- Simultaneous events:
  - MEM in execute and CTRL in decode in the same cycle: MEM stall first. CTRL handling begins the first cycle after mem_state returns to 3, with the branch still in decode.
  - complete_instr = 0 during a stall is ignored.
- Timeout:
  - An 8-bit counter resets on each phase entry.
  - On reaching MEM_TIMEOUT without complete_data: mem_err = 1 (sticky until reset), the phase is abandoned, and the machine behaves as if complete_data had arrived.
- Reset mid-operation: async return to reset values from any state; an in-flight memory access is dropped (mem_state = 3 immediately).

Test Plan:
- Reset release then 4 ALU instrs (ADD 0001), complete_instr = 1 -> enables rise in fetch/decode/execute/writeback order on cycles 1/2/3/4; br_taken = 0; mem_state = 3 throughout.
- LDR in execute, complete_data after 3 cycles -> mem_state = 0 for 3 cycles, all enables 0; then mem_state = 3, enable_writeback = 1 for one cycle; STR in same setup -> mem_state = 1, enable_writeback = 0.
- LDI with complete_data after 2 and then 1 cycles -> mem_state sequence 2,2,0,3; enables 0 until mem_state = 3.
- BRz (ir = 16'h0405), nzp = 3'b010 -> br_taken = 1 at T+2 with enable_updatepc = 1, enable_fetch = 0; repeat with nzp = 3'b001 -> br_taken = 0; JMP -> br_taken = 1 regardless of nzp.
- complete_data held 0 with MEM_TIMEOUT = 4 -> mem_err = 1 after 4 cycles, mem_state = 3 the following cycle, pipeline resumes; reset driven 0 mid-LDI -> all outputs at reset values within the same cycle.
- complete_instr = 0 for 2 cycles in RUN -> enable_fetch = 1, all other enables 0, valid flags unchanged; MEM in execute with CTRL in decode -> MEM stall completes before the branch's T+1 cycle.

Source files
------------

// File: rtl/lc3_controller.sv
// ---------------------------------------------------------------------------
// lc3_controller
//   Pipeline sequencer for the LC3 core. Produces the per-stage enables for
//   fetch / decode / execute / writeback, the PC-update and branch-taken
//   controls for fetch, and the data-memory phase indicator. The pipeline is
//   held while a data-memory access (one or two phases) or a control-flow
//   instruction is in progress.
//
// Ports
//   clock            in   rising-edge clock
//   reset            in   asynchronous active-low reset
//   complete_instr   in   instruction memory returned valid data this cycle
//   complete_data    in   data memory finished the current phase this cycle
//   ir[15:0]         in   instruction in decode
//   ir_exec[15:0]    in   instruction in execute
//   nzp[2:0]         in   condition codes {N,Z,P} from writeback
//   enable_fetch     out  fetch enable (instruction memory read)
//   enable_updatepc  out  PC register update enable
//   enable_decode    out  decode stage enable
//   enable_execute   out  execute stage enable
//   enable_writeback out  writeback stage enable
//   br_taken         out  fetch loads the target address on PC update
//   mem_state[1:0]   out  0 read, 1 write, 2 indirect address read, 3 idle
//   mem_err          out  sticky memory-phase timeout flag
//   fsm_state[2:0]   out  current sequencer state (debug)
//
// Handshake: complete_instr / complete_data are single-cycle "done" strobes
// sampled on the rising clock edge; there is no back-pressure towards the
// memories, the enables simply stay low until the strobe arrives (or the
// phase times out).
// ---------------------------------------------------------------------------
module lc3_controller #(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        complete_instr,
    input  logic        complete_data,
    input  logic [15:0] ir,
    input  logic [15:0] ir_exec,
    input  logic [2:0]  nzp,
    output logic        enable_fetch,
    output logic        enable_updatepc,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        br_taken,
    output logic [1:0]  mem_state,
    output logic        mem_err,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {
        S_RUN = 3'd0,   // normal flow
        S_IND = 3'd1,   // indirect address read (LDI/STI first phase)
        S_RD  = 3'd2,   // data read phase
        S_WR  = 3'd3,   // data write phase
        S_BR1 = 3'd4,   // control instruction executing
        S_BR2 = 3'd5    // PC update with branch decision
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state, next_state;
    logic       v_fet, v_dec, v_exe, v_wb;
    logic       ind_wr;       // indirect op is a store (second phase writes)
    logic [7:0] cnt;

    logic [3:0] exe_op, dec_op;
    logic       exe_is_mem, exe_is_load, exe_is_ind, dec_is_ctrl;
    logic       phase_done, mem_start, br_start;
    logic       unused_bits;

    assign exe_op      = ir_exec[15:12];
    assign dec_op      = ir[15:12];
    assign exe_is_mem  = exe_op inside {4'b0010, 4'b0110, 4'b1010, 4'b0011, 4'b0111, 4'b1011};
    assign exe_is_load = exe_op inside {4'b0010, 4'b0110, 4'b1010};
    assign exe_is_ind  = exe_op inside {4'b1010, 4'b1011};
    assign dec_is_ctrl = dec_op inside {4'b0000, 4'b1100};
    assign unused_bits = ^{ir[11:0], ir_exec[8:0]};

    // A timed-out phase is treated exactly like a completed one.
    assign phase_done = complete_data || (cnt == TO_LAST);
    assign fsm_state  = state;

    always_comb begin
        next_state       = state;
        enable_fetch     = 1'b0;
        enable_updatepc  = 1'b0;
        enable_decode    = 1'b0;
        enable_execute   = 1'b0;
        enable_writeback = 1'b0;
        br_taken         = 1'b0;
        mem_state        = 2'd3;
        mem_start        = 1'b0;
        br_start         = 1'b0;
        case (state)
            S_RUN: begin
                enable_fetch     = v_fet;
                enable_updatepc  = v_fet & complete_instr;
                enable_decode    = v_dec & complete_instr;
                enable_execute   = v_exe & complete_instr;
                enable_writeback = v_wb  & complete_instr;
                // Memory access in execute wins over a control op in decode;
                // the control op stays in decode and is seen again afterwards.
                if (enable_execute && exe_is_mem) begin
                    mem_start  = 1'b1;
                    next_state = exe_is_ind ? S_IND : (exe_is_load ? S_RD : S_WR);
                end else if (enable_decode && dec_is_ctrl) begin
                    br_start   = 1'b1;
                    next_state = S_BR1;
                end
            end
            S_IND: begin
                mem_state = 2'd2;
                if (phase_done) next_state = ind_wr ? S_WR : S_RD;
            end
            S_RD: begin
                mem_state = 2'd0;
                if (phase_done) next_state = S_RUN;
            end
            S_WR: begin
                mem_state = 2'd1;
                if (phase_done) next_state = S_RUN;
            end
            S_BR1: begin
                enable_execute   = v_exe;
                enable_writeback = v_wb;
                next_state       = S_BR2;
            end
            S_BR2: begin
                enable_updatepc = 1'b1;
                br_taken        = (exe_op == 4'b1100) ||
                                  ((exe_op == 4'b0000) && ((ir_exec[11:9] & nzp) != 3'b000));
                next_state      = S_RUN;
            end
            default: next_state = S_RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_RUN;
            v_fet   <= 1'b0;
            v_dec   <= 1'b0;
            v_exe   <= 1'b0;
            v_wb    <= 1'b0;
            ind_wr  <= 1'b0;
            cnt     <= 8'd0;
            mem_err <= 1'b0;
        end else begin
            state <= next_state;
            v_fet <= 1'b1;
            case (state)
                S_RUN: begin
                    if (mem_start) begin
                        // The memory op leaves execute; it writes back only if it loads.
                        v_exe  <= 1'b0;
                        v_wb   <= exe_is_load;
                        ind_wr <= ~exe_is_load;
                        cnt    <= 8'd0;
                    end else if (br_start) begin
                        // Instruction fetched behind the branch is discarded.
                        v_dec <= 1'b0;
                        v_exe <= 1'b1;
                        v_wb  <= v_exe;
                    end else if (complete_instr) begin
                        v_dec <= v_fet;
                        v_exe <= v_dec;
                        v_wb  <= v_exe;
                    end
                end
                S_IND, S_RD, S_WR: begin
                    if (phase_done) begin
                        cnt <= 8'd0;
                        if (!complete_data) mem_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_BR1: begin
                    v_exe <= 1'b0;
                    v_wb  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_controller.sv
module tb_lc3_controller;

  localparam int TO = 4;

  logic        clock;
  logic        reset;
  logic        complete_instr;
  logic        complete_data;
  logic [15:0] ir;
  logic [15:0] ir_exec;
  logic [2:0]  nzp;
  logic        enable_fetch, enable_updatepc, enable_decode;
  logic        enable_execute, enable_writeback, br_taken;
  logic [1:0]  mem_state;
  logic        mem_err;
  logic [2:0]  fsm_state;

  lc3_controller #(.MEM_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .complete_instr(complete_instr), .complete_data(complete_data),
    .ir(ir), .ir_exec(ir_exec), .nzp(nzp),
    .enable_fetch(enable_fetch), .enable_updatepc(enable_updatepc),
    .enable_decode(enable_decode), .enable_execute(enable_execute),
    .enable_writeback(enable_writeback), .br_taken(br_taken),
    .mem_state(mem_state), .mem_err(mem_err), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    reset = 1'b0;
    complete_instr = 1'b1;
    complete_data = 1'b0;
    ir = 16'h1000;
    ir_exec = 16'h1000;
    nzp = 3'b000;
  end

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  // ---------------- reference model ----------------
  // Pipeline occupancy per stage (fetch, decode, execute, writeback), a list of
  // memory phases still to run, and a countdown of the control-flow bubble.
  bit m_v[4];
  int m_phases[$];
  int m_ticks;
  int m_br;
  bit m_err;

  function automatic bit is_load_op(logic [3:0] op);
    return (op == 4'h2) || (op == 4'h6) || (op == 4'hA);
  endfunction

  function automatic bit is_store_op(logic [3:0] op);
    return (op == 4'h3) || (op == 4'h7) || (op == 4'hB);
  endfunction

  function automatic bit is_ctrl_op(logic [3:0] op);
    return (op == 4'h0) || (op == 4'hC);
  endfunction

  function void model_reset();
    for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
    m_phases.delete();
    m_ticks = 0;
    m_br = 0;
    m_err = 1'b0;
  endfunction

  function automatic logic [8:0] model_out();
    logic f, u, d, e, w, b;
    logic [1:0] ms;
    f = 0; u = 0; d = 0; e = 0; w = 0; b = 0; ms = 2'd3;
    if (!reset) begin
      ms = 2'd3;
    end else if (m_phases.size() > 0) begin
      ms = 2'(m_phases[0]);
    end else if (m_br == 1) begin
      e = m_v[2];
      w = m_v[3];
    end else if (m_br == 2) begin
      u = 1'b1;
      if (ir_exec[15:12] == 4'hC) b = 1'b1;
      else if (ir_exec[15:12] == 4'h0) b = ((ir_exec[11:9] & nzp) != 3'b000);
    end else begin
      f = m_v[0];
      u = m_v[0] && complete_instr;
      d = m_v[1] && complete_instr;
      e = m_v[2] && complete_instr;
      w = m_v[3] && complete_instr;
    end
    return {f, u, d, e, w, b, ms, m_err};
  endfunction

  // Advance the model by one rising edge, using the inputs the DUT sampled.
  function void model_edge();
    logic [3:0] eop;
    eop = ir_exec[15:12];
    if (m_phases.size() > 0) begin
      if (complete_data) begin
        void'(m_phases.pop_front());
        m_ticks = 0;
      end else if (m_ticks == TO - 1) begin
        m_err = 1'b1;
        void'(m_phases.pop_front());
        m_ticks = 0;
      end else begin
        m_ticks++;
      end
    end else if (m_br == 1) begin
      m_br = 2;
      m_v[2] = 1'b0;
      m_v[3] = 1'b0;
    end else if (m_br == 2) begin
      m_br = 0;
    end else if (complete_instr) begin
      if (m_v[2] && (is_load_op(eop) || is_store_op(eop))) begin
        if (eop == 4'hA) begin m_phases.push_back(2); m_phases.push_back(0); end
        else if (eop == 4'hB) begin m_phases.push_back(2); m_phases.push_back(1); end
        else if (is_load_op(eop)) m_phases.push_back(0);
        else m_phases.push_back(1);
        m_ticks = 0;
        m_v[3] = is_load_op(eop);
        m_v[2] = 1'b0;
      end else if (m_v[1] && is_ctrl_op(ir[15:12])) begin
        m_br = 1;
        m_v[3] = m_v[2];
        m_v[2] = 1'b1;
        m_v[1] = 1'b0;
      end else begin
        m_v[3] = m_v[2];
        m_v[2] = m_v[1];
        m_v[1] = m_v[0];
      end
    end
    m_v[0] = 1'b1;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic ci, input logic cd,
                      input logic [15:0] i_dec, input logic [15:0] i_exe,
                      input logic [2:0] n);
    @(posedge clock);
    #1;
    if (reset) model_edge();
    reset = r;
    if (!reset) model_reset();
    complete_instr = ci;
    complete_data = cd;
    ir = i_dec;
    ir_exec = i_exe;
    nzp = n;
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b1, 1'b0, 16'h1042, 16'h1283, 3'b000);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    logic [8:0] exp_v, act_v;
    cyc++;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {enable_fetch, enable_updatepc, enable_decode, enable_execute,
               enable_writeback, br_taken, mem_state, mem_err};
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL outputs cycle %0d {fe,upc,de,ex,wb,br,ms,err}: actual=%b required=%b",
                 cyc, act_v, exp_v);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] a, b;
    // reset held, then release and fill with ADDs
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 16'h1042, 16'h1283, 3'b000);
    idle(6);

    // LDR in execute, complete_data on the third phase cycle
    step(1'b1, 1'b1, 1'b0, 16'h1042, 16'h6285, 3'b000);
    step(1'b1, 1'b1, 1'b0, 16'h1042, 16'h1283, 3'b000);
    step(1'b1, 1'b1, 1'b0, 16'h1042, 16'h1283, 3'b000);
    step(1'b1, 1'b1, 1'b1, 16'h1042, 16'h1283, 3'b000);
    idle(4);

    // STR in the same setup
    step(1'b1, 1'b1, 1'b0, 16'h1042, 16'h7285, 3'b000);
    step(1'b1, 1'b1, 1'b0, 16'h1042, 16'h1283, 3'b000);
    step(1'b1, 1'b1, 1'b0, 16'h1042, 16'h1283, 3'b000);
    step(1'b1, 1'b1, 1'b1, 16'h1042, 16'h1283, 3'b000);
    idle(4);

    // LDI: address phase done after 2 cycles, data phase after 1
    step(1'b1, 1'b1, 1'b0, 16'h1042, 16'hA203, 3'b000);
    step(1'b1, 1'b1, 1'b0, 16'h1042, 16'h1283, 3'b000);
    step(1'b1, 1'b1, 1'b1, 16'h1042, 16'h1283, 3'b000);
    step(1'b1, 1'b1, 1'b1, 16'h1042, 16'h1283, 3'b000);
    idle(4);

    // BRz taken, BRz not taken, JMP, BR with empty condition mask
    for (int t = 0; t < 4; t++) begin
      case (t)
        0: begin a = 16'h0405; b = 16'h0000; end
        1: begin a = 16'h0405; b = 16'h0001; end
        2: begin a = 16'hC1C0; b = 16'h0000; end
        default: begin a = 16'h0005; b = 16'h0007; end
      endcase
      step(1'b1, 1'b1, 1'b0, a, 16'h1283, 3'b000);
      step(1'b1, 1'b1, 1'b0, 16'h1042, a, (t == 0) ? 3'b010 : b[2:0]);
      step(1'b1, 1'b1, 1'b0, 16'h1042, a, (t == 0) ? 3'b010 : b[2:0]);
      idle(5);
    end

    // timeout: complete_data never arrives
    step(1'b1, 1'b1, 1'b0, 16'h1042, 16'h2403, 3'b000);
    idle(8);

    // reset asserted while an LDI is in its address phase
    step(1'b1, 1'b1, 1'b0, 16'h1042, 16'hA203, 3'b000);
    step(1'b1, 1'b1, 1'b0, 16'h1042, 16'h1283, 3'b000);
    step(1'b0, 1'b1, 1'b0, 16'h1042, 16'h1283, 3'b000);
    step(1'b0, 1'b1, 1'b0, 16'h1042, 16'h1283, 3'b000);
    idle(6);

    // instruction memory wait for two cycles
    step(1'b1, 1'b0, 1'b0, 16'h1042, 16'h1283, 3'b000);
    step(1'b1, 1'b0, 1'b0, 16'h1042, 16'h1283, 3'b000);
    idle(3);

    // LD in execute with a BR in decode: memory first, branch afterwards
    step(1'b1, 1'b1, 1'b0, 16'h0E02, 16'h2403, 3'b000);
    step(1'b1, 1'b0, 1'b1, 16'h0E02, 16'h1283, 3'b000);
    step(1'b1, 1'b1, 1'b0, 16'h0E02, 16'h1283, 3'b000);
    step(1'b1, 1'b1, 1'b0, 16'h1042, 16'h0E02, 3'b100);
    step(1'b1, 1'b1, 1'b0, 16'h1042, 16'h0E02, 3'b100);
    idle(5);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 99) < 85),
           ($urandom_range(0, 99) < 45), a, b, 3'($urandom_range(0, 7)));
    end
    idle(3);

    @(negedge clock);
    @(negedge clock);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
